pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Supervises the system PLL (100 MHz refclk in; 75/25/1 MHz out) and sequences its reset.
- Holds the PLL in reset, waits for lock with a timeout and retries, then requires lock to stay stable.
- Then releases the downstream clock-domain resets one stage at a time.
- Runs on the free-running refclk. Loss of lock re-arms the whole sequence. Each downstream domain synchronises its own reset deassertion.

Parameters:
- RST_HOLD_CYCLES, 1000: refclk cycles pll_rst is held high per attempt.
- LOCK_TIMEOUT_CYCLES, 100000: cycles allowed for the synchronised lock to rise.
- LOCK_STABLE_CYCLES, 1024: consecutive locked cycles required before release.
- STAGE_GAP_CYCLES, 16: cycles between successive dom_rst deassertions.
- NUM_STAGES, 3: number of downstream reset outputs.
- MAX_RETRIES, 7: lock timeouts tolerated before entering FAIL.

Ports:
- refclk, in, 1: 100 MHz free-running clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- locked_i, in, 1: PLL locked, asynchronous; 2-FF synchronised internally.
- relock_req, in, 1: single-cycle pulse; restarts the sequence from any state.
- pll_rst, out, 1: reset to the PLL.
- dom_rst, out, NUM_STAGES: per-domain reset, active-high; bit 0 is released first.
- ready, out, 1: all domains out of reset and lock held.
- lock_fail, out, 1: retries exhausted.
- retry_count, out, clog2(MAX_RETRIES+1): timeouts in the current sequence.
- lock_loss_count, out, 8: saturating count of lock losses while in RELEASE or RUN.
- state_o, out, 3: current state encoding, for debug.

Behaviour:
- Only one clock (refclk). Reset is synchronous and active-high. All outputs are registered.
- While rst=1: state=PLL_RST, pll_rst=1, dom_rst=all 1s, ready=0, lock_fail=0, retry_count=0, lock_loss_count=0, counters=0.
- Synchroniser: locked_s lags locked_i by 2 cycles. Only locked_s is used.
- States:
  - PLL_RST: pll_rst=1. After exactly RST_HOLD_CYCLES cycles in this state, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0; timeout counter runs.
    - locked_s=1 → STABLE.
    - Counter reaches LOCK_TIMEOUT_CYCLES-1 with locked_s=0 → retry_count+1. If the new value equals MAX_RETRIES → FAIL, else → PLL_RST.
  - STABLE: stable counter increments while locked_s=1.
    - locked_s=0 → WAIT_LOCK with both counters cleared; this does not count as a retry.
    - LOCK_STABLE_CYCLES consecutive cycles → RELEASE, with dom_rst[0]=0 on the entry edge.
  - RELEASE: dom_rst[k] falls exactly STAGE_GAP_CYCLES cycles after dom_rst[k-1]. One cycle after dom_rst[NUM_STAGES-1] falls → RUN, ready=1, retry_count cleared.
  - RUN: hold outputs.
  - FAIL: pll_rst=1, dom_rst all 1s, lock_fail=1. Exits only via relock_req or rst.
- Lock loss in RELEASE or RUN (locked_s=0):
  - On the next edge: dom_rst all 1s, ready=0, lock_loss_count+1 (saturates at 255), state → PLL_RST.
- relock_req=1, any state:
  - Next edge: PLL_RST, dom_rst all 1s, ready=0, lock_fail=0, retry_count=0.
  - Coincides with lock loss → lock_loss_count is incremented once.
- rst has priority over relock_req.
- Once set, dom_rst bits only fall during RELEASE. Every other path reasserts all of them in a single cycle.
- Counters are sized clog2 of their limit; they never wrap. Each is cleared on every state entry.

Decomposition:
- Package pll_seq_pkg:
  - State encoding constants: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.
  - State width = 3.
  - Counter width function (clog2).
- Sub-module sync_2ff: generic 2-flop synchroniser, reset value 0, used for locked_i.
- Everything else stays in a single FSM plus counter process.

Test Plan:
Bench parameters for all scenarios: RST_HOLD=8, TIMEOUT=64, STABLE=16, GAP=4, NUM_STAGES=3, MAX_RETRIES=2.
1. Clean lock: locked_i rises 20 cycles after rst release → pll_rst low at cycle 8; STABLE entered 2 cycles after locked_i rises; dom_rst bits fall 16, 20, 24 cycles after STABLE entry; ready=1 one cycle later.
2. Timeout/retry/fail: locked_i held 0 → two attempts of 8+64 cycles each; retry_count 1 then 2; then FAIL with lock_fail=1, pll_rst=1, dom_rst=3'b111.
3. Glitch in STABLE: locked_i drops for 3 cycles at stable count 10 → state returns to WAIT_LOCK; retry_count unchanged; release happens only after a fresh 16-cycle run.
4. Lock loss in RUN: locked_i falls → 2 cycles later dom_rst=3'b111 and ready=0 on the same edge; lock_loss_count=1; full resequence follows.
5. relock_req from FAIL, plus a coincident relock_req and lock loss in RUN → PLL_RST next cycle, lock_fail=0, retry_count=0; lock_loss_count increments by exactly 1.
6. rst asserted mid-RELEASE (after dom_rst[0] has fallen) → next edge: all reset values, lock_loss_count=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and
// counter sizing helper.
package pll_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } state_t;

   // Bits needed to hold 0..limit-1, never less than one.
   function automatic int cnt_w(input int limit);
      return (limit > 2) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs; clears to 0
// under synchronous reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: holds the PLL in reset, waits for a stable lock with
// timeout/retry, then releases downstream domain resets one stage at a time.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = 1000,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int STAGE_GAP_CYCLES    = 16,
   parameter int NUM_STAGES          = 3,
   parameter int MAX_RETRIES         = 7
) (
   input  logic                              refclk,
   input  logic                              rst,
   input  logic                              locked_i,
   input  logic                              relock_req,
   output logic                              pll_rst,
   output logic [NUM_STAGES-1:0]             dom_rst,
   output logic                              ready,
   output logic                              lock_fail,
   output logic [cnt_w(MAX_RETRIES+1)-1:0]   retry_count,
   output logic [7:0]                        lock_loss_count,
   output logic [STATE_W-1:0]                state_o
);

   localparam int HOLD_W  = cnt_w(RST_HOLD_CYCLES);
   localparam int TO_W    = cnt_w(LOCK_TIMEOUT_CYCLES);
   localparam int STAB_W  = cnt_w(LOCK_STABLE_CYCLES);
   localparam int GAP_W   = cnt_w(STAGE_GAP_CYCLES);
   localparam int RETRY_W = cnt_w(MAX_RETRIES+1);

   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(STAGE_GAP_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   state_t            state;
   logic              locked_s;
   logic              lost;
   logic [HOLD_W-1:0] hold_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [STAB_W-1:0] stab_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (locked_i),
      .q   (locked_s)
   );

   assign lost    = ((state == RELEASE) || (state == RUN)) && !locked_s;
   assign state_o = state;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state           <= PLL_RST;
         pll_rst         <= 1'b1;
         dom_rst         <= '1;
         ready           <= 1'b0;
         lock_fail       <= 1'b0;
         retry_count     <= '0;
         lock_loss_count <= '0;
         hold_cnt        <= '0;
         to_cnt          <= '0;
         stab_cnt        <= '0;
         gap_cnt         <= '0;
      end else begin
         // Counters fall back to zero unless the current state advances its own,
         // so every state entry starts from a cleared counter.
         hold_cnt <= '0;
         to_cnt   <= '0;
         stab_cnt <= '0;
         gap_cnt  <= '0;

         if (lost && (lock_loss_count != 8'hFF))
            lock_loss_count <= lock_loss_count + 8'd1;

         if (relock_req) begin
            state       <= PLL_RST;
            pll_rst     <= 1'b1;
            dom_rst     <= '1;
            ready       <= 1'b0;
            lock_fail   <= 1'b0;
            retry_count <= '0;
         end else begin
            case (state)
               PLL_RST: begin
                  pll_rst <= 1'b1;
                  if (hold_cnt == HOLD_LAST) begin
                     state   <= WAIT_LOCK;
                     pll_rst <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end

               WAIT_LOCK: begin
                  if (locked_s) begin
                     state <= STABLE;
                  end else if (to_cnt == TO_LAST) begin
                     retry_count <= retry_count + 1'b1;
                     pll_rst     <= 1'b1;
                     if ((retry_count + 1'b1) == RETRY_MAX) begin
                        state     <= FAIL;
                        lock_fail <= 1'b1;
                     end else begin
                        state <= PLL_RST;
                     end
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end

               STABLE: begin
                  if (!locked_s) begin
                     state <= WAIT_LOCK;
                  end else if (stab_cnt == STAB_LAST) begin
                     state   <= RELEASE;
                     dom_rst <= {NUM_STAGES{1'b1}} << 1;
                  end else begin
                     stab_cnt <= stab_cnt + 1'b1;
                  end
               end

               // dom_rst shifts left, so released bits fill from bit 0 upward.
               RELEASE: begin
                  if (!locked_s) begin
                     state   <= PLL_RST;
                     pll_rst <= 1'b1;
                     dom_rst <= '1;
                     ready   <= 1'b0;
                  end else if (dom_rst == '0) begin
                     state       <= RUN;
                     ready       <= 1'b1;
                     retry_count <= '0;
                  end else if (gap_cnt == GAP_LAST) begin
                     dom_rst <= dom_rst << 1;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end

               RUN: begin
                  if (!locked_s) begin
                     state   <= PLL_RST;
                     pll_rst <= 1'b1;
                     dom_rst <= '1;
                     ready   <= 1'b0;
                  end
               end

               FAIL: begin
                  pll_rst   <= 1'b1;
                  dom_rst   <= '1;
                  ready     <= 1'b0;
                  lock_fail <= 1'b1;
               end

               default: begin
                  state   <= PLL_RST;
                  pll_rst <= 1'b1;
                  dom_rst <= '1;
                  ready   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: per-scenario tables of {wait, inputs, expected
// outputs}, expectations queued at drive time and compared by a monitor.
module tb_pll_reset_sequencer;

   localparam logic [2:0] S_RST  = 3'd0;
   localparam logic [2:0] S_WL   = 3'd1;
   localparam logic [2:0] S_ST   = 3'd2;
   localparam logic [2:0] S_RL   = 3'd3;
   localparam logic [2:0] S_RUN  = 3'd4;
   localparam logic [2:0] S_FAIL = 3'd5;

   typedef struct {
      int         n;
      logic       lk;
      logic       rq;
      logic [2:0] st;
      logic       pll;
      logic [2:0] dom;
      logic       rdy;
      logic       fl;
      logic [1:0] rc;
      logic [7:0] llc;
   } vec_t;

   typedef struct {
      int         cyc;
      string      nm;
      logic [2:0] st;
      logic       pll;
      logic [2:0] dom;
      logic       rdy;
      logic       fl;
      logic [1:0] rc;
      logic [7:0] llc;
   } exp_t;

   logic       refclk, rst, locked_i, relock_req;
   logic       pll_rst, ready, lock_fail;
   logic [2:0] dom_rst, state_o;
   logic [1:0] retry_count;
   logic [7:0] lock_loss_count;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t tbl[$];

   pll_reset_sequencer #(
      .RST_HOLD_CYCLES(8), .LOCK_TIMEOUT_CYCLES(64), .LOCK_STABLE_CYCLES(16),
      .STAGE_GAP_CYCLES(4), .NUM_STAGES(3), .MAX_RETRIES(2)
   ) dut (
      .refclk          (refclk),
      .rst             (rst),
      .locked_i        (locked_i),
      .relock_req      (relock_req),
      .pll_rst         (pll_rst),
      .dom_rst         (dom_rst),
      .ready           (ready),
      .lock_fail       (lock_fail),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count),
      .state_o         (state_o)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;
   always @(posedge refclk) cyc <= cyc + 1;

   function automatic vec_t V(input int n, input logic lk, input logic rq,
                              input logic [2:0] st, input logic pll,
                              input logic [2:0] dom, input logic rdy,
                              input logic fl, input logic [1:0] rc,
                              input logic [7:0] llc);
      vec_t v;
      v.n = n; v.lk = lk; v.rq = rq; v.st = st; v.pll = pll; v.dom = dom;
      v.rdy = rdy; v.fl = fl; v.rc = rc; v.llc = llc;
      return v;
   endfunction

   task automatic chk(input exp_t e);
      n_chk++;
      if (state_o !== e.st || pll_rst !== e.pll || dom_rst !== e.dom ||
          ready !== e.rdy || lock_fail !== e.fl || retry_count !== e.rc ||
          lock_loss_count !== e.llc) begin
         n_err++;
         $display("FAIL %s: got st=%0d pll_rst=%b dom_rst=%b ready=%b lock_fail=%b retry=%0d loss=%0d; want st=%0d pll_rst=%b dom_rst=%b ready=%b lock_fail=%b retry=%0d loss=%0d",
                  e.nm, state_o, pll_rst, dom_rst, ready, lock_fail, retry_count,
                  lock_loss_count, e.st, e.pll, e.dom, e.rdy, e.fl, e.rc, e.llc);
      end
   endtask

   // Drive each row's inputs, queue its expectation n edges ahead, then wait.
   task automatic run(input string tag, input vec_t v[$]);
      exp_t e;
      for (int i = 0; i < v.size(); i++) begin
         locked_i   = v[i].lk;
         relock_req = v[i].rq;
         e.cyc = cyc + v[i].n;
         e.nm  = $sformatf("%s[%0d]", tag, i);
         e.st = v[i].st; e.pll = v[i].pll; e.dom = v[i].dom; e.rdy = v[i].rdy;
         e.fl = v[i].fl; e.rc = v[i].rc; e.llc = v[i].llc;
         sb.push_back(e);
         @(negedge refclk);
         relock_req = 1'b0;
         repeat (v[i].n - 1) @(negedge refclk);
      end
   endtask

   always @(negedge refclk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.cyc < cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: expectation for cycle %0d not compared (now %0d)",
                     mon_e.nm, mon_e.cyc, cyc);
         end else begin
            chk(mon_e);
         end
      end
   end

   initial begin
      exp_t r;
      rst = 1'b1; locked_i = 1'b0; relock_req = 1'b0;
      repeat (3) @(negedge refclk);
      r.cyc = cyc; r.nm = "reset_state"; r.st = S_RST; r.pll = 1'b1; r.dom = 3'b111;
      r.rdy = 1'b0; r.fl = 1'b0; r.rc = 2'd0; r.llc = 8'd0;
      chk(r);
      rst = 1'b0;

      // Clean lock, locked_i first sampled on edge 21.
      tbl = {};
      tbl.push_back(V( 7, 0, 0, S_RST, 1, 3'b111, 0, 0, 0, 0));
      tbl.push_back(V( 1, 0, 0, S_WL,  0, 3'b111, 0, 0, 0, 0));
      tbl.push_back(V(12, 0, 0, S_WL,  0, 3'b111, 0, 0, 0, 0));
      tbl.push_back(V( 2, 1, 0, S_WL,  0, 3'b111, 0, 0, 0, 0));
      tbl.push_back(V( 1, 1, 0, S_ST,  0, 3'b111, 0, 0, 0, 0));
      tbl.push_back(V(15, 1, 0, S_ST,  0, 3'b111, 0, 0, 0, 0));
      tbl.push_back(V( 1, 1, 0, S_RL,  0, 3'b110, 0, 0, 0, 0));
      tbl.push_back(V( 3, 1, 0, S_RL,  0, 3'b110, 0, 0, 0, 0));
      tbl.push_back(V( 1, 1, 0, S_RL,  0, 3'b100, 0, 0, 0, 0));
      tbl.push_back(V( 4, 1, 0, S_RL,  0, 3'b000, 0, 0, 0, 0));
      tbl.push_back(V( 1, 1, 0, S_RUN, 0, 3'b000, 1, 0, 0, 0));
      tbl.push_back(V( 5, 1, 0, S_RUN, 0, 3'b000, 1, 0, 0, 0));
      run("clean_lock", tbl);

      // Lock loss in RUN and full resequence.
      tbl = {};
      tbl.push_back(V( 2, 0, 0, S_RUN, 0, 3'b000, 1, 0, 0, 0));
      tbl.push_back(V( 1, 0, 0, S_RST, 1, 3'b111, 0, 0, 0, 1));
      tbl.push_back(V( 7, 1, 0, S_RST, 1, 3'b111, 0, 0, 0, 1));
      tbl.push_back(V( 1, 1, 0, S_WL,  0, 3'b111, 0, 0, 0, 1));
      tbl.push_back(V( 1, 1, 0, S_ST,  0, 3'b111, 0, 0, 0, 1));
      tbl.push_back(V(16, 1, 0, S_RL,  0, 3'b110, 0, 0, 0, 1));
      tbl.push_back(V( 8, 1, 0, S_RL,  0, 3'b000, 0, 0, 0, 1));
      tbl.push_back(V( 1, 1, 0, S_RUN, 0, 3'b000, 1, 0, 0, 1));
      run("lock_loss_run", tbl);

      // relock_req on the same edge the lock loss is seen: one increment.
      tbl = {};
      tbl.push_back(V( 2, 0, 0, S_RUN, 0, 3'b000, 1, 0, 0, 1));
      tbl.push_back(V( 1, 0, 1, S_RST, 1, 3'b111, 0, 0, 0, 2));
      run("relock_and_loss", tbl);

      // No lock: two 8+64 attempts, then FAIL.
      tbl = {};
      tbl.push_back(V( 8, 0, 0, S_WL,   0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V(63, 0, 0, S_WL,   0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 1, 0, 0, S_RST,  1, 3'b111, 0, 0, 1, 2));
      tbl.push_back(V( 8, 0, 0, S_WL,   0, 3'b111, 0, 0, 1, 2));
      tbl.push_back(V(63, 0, 0, S_WL,   0, 3'b111, 0, 0, 1, 2));
      tbl.push_back(V( 1, 0, 0, S_FAIL, 1, 3'b111, 0, 1, 2, 2));
      tbl.push_back(V(10, 0, 0, S_FAIL, 1, 3'b111, 0, 1, 2, 2));
      run("timeout_fail", tbl);

      // relock_req out of FAIL, then a 3-cycle lock glitch at stable count 10.
      tbl = {};
      tbl.push_back(V( 1, 1, 1, S_RST, 1, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 7, 1, 0, S_RST, 1, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 1, 1, 0, S_WL,  0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 1, 1, 0, S_ST,  0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V(10, 1, 0, S_ST,  0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 2, 0, 0, S_ST,  0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 1, 0, 0, S_WL,  0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 2, 1, 0, S_WL,  0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 1, 1, 0, S_ST,  0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V(15, 1, 0, S_ST,  0, 3'b111, 0, 0, 0, 2));
      tbl.push_back(V( 1, 1, 0, S_RL,  0, 3'b110, 0, 0, 0, 2));
      run("fail_relock_glitch", tbl);

      // rst mid-RELEASE, after dom_rst[0] has fallen.
      rst = 1'b1;
      @(negedge refclk);
      r.cyc = cyc; r.nm = "rst_mid_release"; r.st = S_RST; r.pll = 1'b1; r.dom = 3'b111;
      r.rdy = 1'b0; r.fl = 1'b0; r.rc = 2'd0; r.llc = 8'd0;
      chk(r);
      rst = 1'b0;
      repeat (2) @(negedge refclk);

      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
